// File: rtl/apb_cmd_arbiter_if.sv
// apb_cmd_arbiter_if: requester-side and apb_master-side bundle of the arbiter.
// slave modport = arbiter view; master modport = clients + apb_master view.
//   i_req_cmd/i_req_valid/i_req_lock : N requester commands, valids, locks
//   o_req_ready/o_req_resp           : completion pulse and broadcast response
//   o_grant/o_busy                   : current one-hot grant, transfer in flight
//   o_m_cmd/o_m_valid                : command toward apb_master
//   i_m_ready/i_m_resp               : completion and response from apb_master
interface apb_cmd_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int AW = 8
);
    localparam int SW = 4;
    localparam int CW = 1 + SW + DW + AW;
    localparam int RW = 1 + DW;

    logic [N*CW-1:0] i_req_cmd;
    logic [N-1:0]    i_req_valid;
    logic [N-1:0]    i_req_lock;
    logic [N-1:0]    o_req_ready;
    logic [RW-1:0]   o_req_resp;
    logic [N-1:0]    o_grant;
    logic            o_busy;
    logic [CW-1:0]   o_m_cmd;
    logic            o_m_valid;
    logic            i_m_ready;
    logic [RW-1:0]   i_m_resp;

    modport slave (
        input  i_req_cmd,
        input  i_req_valid,
        input  i_req_lock,
        output o_req_ready,
        output o_req_resp,
        output o_grant,
        output o_busy,
        output o_m_cmd,
        output o_m_valid,
        input  i_m_ready,
        input  i_m_resp
    );

    modport master (
        output i_req_cmd,
        output i_req_valid,
        output i_req_lock,
        input  o_req_ready,
        input  o_req_resp,
        input  o_grant,
        input  o_busy,
        input  o_m_cmd,
        input  o_m_valid,
        output i_m_ready,
        output i_m_resp
    );
endinterface

// File: rtl/apb_cmd_arbiter.sv
// apb_cmd_arbiter: round-robin sharing of one apb_master among N requesters.
// Ports: i_clk, i_reset_n (sync, active-low), bus (apb_cmd_arbiter_if.slave).
//   One transfer at a time; the winning command is latched and held to the
//   master until i_m_ready, then a ready pulse goes back to the winner.
module apb_cmd_arbiter #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    apb_cmd_arbiter_if.slave bus
);
    localparam int SW = 4;
    localparam int CW = 1 + SW + DW + AW;
    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_grant;
    logic [IW-1:0] r_gidx;
    logic [IW-1:0] r_rr_ptr;
    logic [CW-1:0] r_cmd;
    logic          r_m_valid;
    logic          r_busy;

    logic          w_found;
    logic [IW-1:0] w_win;
    logic [CW-1:0] w_cmd;
    logic [N-1:0]  w_onehot;
    logic [IW-1:0] w_next;
    logic          w_done;

    // Scan rr_ptr, rr_ptr+1, ... mod N; first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found &&
                bus.i_req_valid[IW'((int'(r_rr_ptr) + i) % N)]) begin
                w_found = 1'b1;
                w_win   = IW'((int'(r_rr_ptr) + i) % N);
            end
        end
    end

    always_comb begin
        w_cmd = '0;
        for (int k = 0; k < N; k++) begin
            if (w_win == IW'(k)) begin
                w_cmd = bus.i_req_cmd[k*CW +: CW];
            end
        end
    end

    assign w_onehot = N'(1) << w_win;

    // Explicit wrap so non-power-of-2 N never reaches an unused index.
    assign w_next = (r_gidx == IW'(N - 1)) ? '0 : r_gidx + 1'b1;

    // A reset cycle never produces a completion pulse.
    assign w_done = (r_state == GRANT) && bus.i_m_ready && i_reset_n;

    assign bus.o_req_ready = w_done ? r_grant : '0;
    assign bus.o_req_resp  = bus.i_m_resp;
    assign bus.o_grant     = r_grant;
    assign bus.o_busy      = r_busy;
    assign bus.o_m_cmd     = r_cmd;
    assign bus.o_m_valid   = r_m_valid;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_rr_ptr  <= '0;
            r_cmd     <= '0;
            r_m_valid <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state   <= GRANT;
                        r_grant   <= w_onehot;
                        r_gidx    <= w_win;
                        r_cmd     <= w_cmd;
                        r_m_valid <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (bus.i_m_ready) begin
                        r_state   <= IDLE;
                        r_grant   <= '0;
                        r_m_valid <= 1'b0;
                        r_busy    <= 1'b0;
                        // Lock keeps the holder first in the next scan.
                        r_rr_ptr  <= bus.i_req_lock[r_gidx] ? r_gidx : w_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// tb_apb_cmd_arbiter: directed plus randomized bench for apb_cmd_arbiter,
// checked every cycle against a transaction-level round-robin model.
module tb_apb_cmd_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 1 + 4 + DW + AW;
    localparam int RW = 1 + DW;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_cmd_arbiter_if #(.N(N), .DW(DW), .AW(AW)) bus ();

    apb_cmd_arbiter #(.N(N), .DW(DW), .AW(AW)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    // model state
    bit            m_busy;
    int            m_own;
    int            m_ptr;
    int            m_age;
    logic [CW-1:0] m_cmd;

    // bench-side slave and requester behaviour
    bit           slv_rdy;
    bit           noise;
    logic [N-1:0] keep;
    logic [N-1:0] e_rdy;

    // snapshots of DUT outputs
    logic [N-1:0]  s_rdy;
    logic [N-1:0]  s_gnt;
    logic          s_mv;
    logic          s_busy;
    logic [CW-1:0] s_mcmd;
    logic [RW-1:0] s_resp;

    int order[$];

    function automatic logic [N-1:0] oh(int k);
        return N'(1) << k;
    endfunction

    function automatic int first1(logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic check_outputs();
        e_rdy = (m_busy && bus.i_m_ready && rst_n) ? oh(m_own) : '0;
        chk("m_valid", 64'(s_mv), 64'(m_busy));
        chk("busy", 64'(s_busy), 64'(m_busy));
        chk("grant", 64'(s_gnt), 64'(m_busy ? oh(m_own) : '0));
        if (m_busy) chk("m_cmd", 64'(s_mcmd), 64'(m_cmd));
        chk("req_ready", 64'(s_rdy), 64'(e_rdy));
        if (e_rdy != '0) chk("req_resp", 64'(s_resp), 64'(bus.i_m_resp));
    endtask

    task automatic step_model();
        int w;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_age  = 0;
        end else if (m_busy) begin
            if (bus.i_m_ready) begin
                m_busy = 1'b0;
                if (bus.i_req_lock[IW'(m_own)]) m_ptr = m_own;
                else m_ptr = (m_own + 1) % N;
            end else begin
                m_age++;
            end
        end else begin
            w = -1;
            for (int i = 0; i < N; i++) begin
                if (w < 0 && bus.i_req_valid[IW'((m_ptr + i) % N)])
                    w = (m_ptr + i) % N;
            end
            if (w >= 0) begin
                m_busy = 1'b1;
                m_own  = w;
                m_cmd  = bus.i_req_cmd[w*CW +: CW];
                m_age  = 0;
            end
        end
    endtask

    // One clock: slave response, sample at negedge, advance model.
    task automatic cyc();
        // APB needs a setup cycle before pready can complete
        bus.i_m_ready = m_busy ? (m_age >= 1 && slv_rdy) : noise;
        @(negedge clk);
        s_rdy  = bus.o_req_ready;
        s_gnt  = bus.o_grant;
        s_mv   = bus.o_m_valid;
        s_busy = bus.o_busy;
        s_mcmd = bus.o_m_cmd;
        s_resp = bus.o_req_resp;
        check_outputs();
        step_model();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (e_rdy[k] && !keep[k]) bus.i_req_valid[k] = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [CW-1:0] c1;
        logic [CW-1:0] c2;
        logic [63:0]   r64;
        int            exp_c[5];
        int            exp_l[4];
        exp_c = '{0, 1, 2, 3, 0};
        exp_l = '{0, 0, 0, 3};

        bus.i_req_cmd   = '0;
        bus.i_req_valid = '1;
        bus.i_req_lock  = '0;
        bus.i_m_ready   = 1'b0;
        bus.i_m_resp    = '0;
        keep    = '1;
        slv_rdy = 1'b0;
        noise   = 1'b0;
        m_busy  = 1'b0;
        m_own   = 0;
        m_ptr   = 0;
        m_age   = 0;
        m_cmd   = '0;
        e_rdy   = '0;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;

        // reset with every requester valid
        repeat (3) begin
            noise = 1'b1;
            cyc();
            chk("rst_mvalid", 64'(s_mv), 64'(0));
            chk("rst_grant", 64'(s_gnt), 64'(0));
            chk("rst_busy", 64'(s_busy), 64'(0));
        end
        noise = 1'b0;

        // single write from requester 1
        rst_n = 1'b1;
        bus.i_req_valid = '0;
        keep    = '0;
        slv_rdy = 1'b1;
        cyc();
        c1 = {1'b1, 4'hF, 32'hDEADBEEF, 8'h10};
        bus.i_req_cmd[1*CW +: CW] = c1;
        bus.i_req_valid[1] = 1'b1;
        cyc();
        chk("wr_t0_idle", 64'(s_mv), 64'(0));
        cyc();
        chk("wr_t1_valid", 64'(s_mv), 64'(1));
        chk("wr_t1_cmd", 64'(s_mcmd), 64'(c1));
        chk("wr_t1_nordy", 64'(s_rdy), 64'(0));
        cyc();
        chk("wr_t2_ready", 64'(s_rdy), 64'(4'b0010));
        cyc();
        chk("wr_bubble", 64'(s_mv), 64'(0));

        // contention, no lock
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            r64 = {$urandom, $urandom};
            bus.i_req_cmd[k*CW +: CW] = r64[CW-1:0];
        end
        bus.i_req_valid = '1;
        keep = '1;
        order.delete();
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            cyc();
            if (s_rdy != '0) order.push_back(first1(s_rdy));
        end
        for (int i = 0; i < 5; i++) begin
            chk("contend_order",
                64'(i < order.size() ? order[i] : -1), 64'(exp_c[i]));
        end
        bus.i_req_valid = '0;
        keep = '0;
        repeat (6) cyc();

        // wait states on a read from requester 2
        slv_rdy = 1'b0;
        bus.i_m_resp = 33'h0_12345678;
        c2 = {1'b0, 4'h0, 32'h0, 8'h20};
        bus.i_req_cmd[2*CW +: CW] = c2;
        bus.i_req_valid[2] = 1'b1;
        cyc();
        repeat (6) begin
            cyc();
            chk("ws_cmd", 64'(s_mcmd), 64'(c2));
            chk("ws_nordy", 64'(s_rdy), 64'(0));
        end
        slv_rdy = 1'b1;
        cyc();
        chk("ws_ready", 64'(s_rdy), 64'(4'b0100));
        chk("ws_resp", 64'(s_resp), 64'(33'h0_12345678));
        chk("ws_cmd_end", 64'(s_mcmd), 64'(c2));
        cyc();

        // lock on requester 0 against requester 3
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.i_req_lock[0] = 1'b1;
        bus.i_req_valid   = 4'b1001;
        keep = 4'b1001;
        order.delete();
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            cyc();
            if (s_rdy != '0) order.push_back(first1(s_rdy));
            if (order.size() >= 2) bus.i_req_lock[0] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            chk("lock_order",
                64'(i < order.size() ? order[i] : -1), 64'(exp_l[i]));
        end
        bus.i_req_valid = '0;
        bus.i_req_lock  = '0;
        keep = '0;
        repeat (6) cyc();

        // move rr pointer away from 0, then reset mid-transfer
        bus.i_req_valid[1] = 1'b1;
        repeat (5) cyc();
        slv_rdy = 1'b0;
        bus.i_req_valid[2] = 1'b1;
        cyc();
        cyc();
        chk("mr_granted", 64'(s_mv), 64'(1));
        rst_n = 1'b0;
        bus.i_req_valid = '0;
        cyc();
        chk("mr_nopulse", 64'(s_rdy), 64'(0));
        rst_n = 1'b1;
        bus.i_req_valid = 4'b1010;
        cyc();
        chk("mr_idle_mv", 64'(s_mv), 64'(0));
        chk("mr_idle_gnt", 64'(s_gnt), 64'(0));
        cyc();
        chk("mr_ptr0_gnt", 64'(s_gnt), 64'(4'b0010));
        bus.i_req_valid = '0;
        slv_rdy = 1'b1;
        repeat (6) cyc();

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (!rst_n) bus.i_req_valid = '0;
            for (int k = 0; k < N; k++) begin
                if (rst_n && !bus.i_req_valid[k] &&
                    $urandom_range(0, 2) == 0) begin
                    r64 = {$urandom, $urandom};
                    bus.i_req_cmd[k*CW +: CW] = r64[CW-1:0];
                    bus.i_req_valid[k] = 1'b1;
                end
                bus.i_req_lock[k] = ($urandom_range(0, 5) == 0);
            end
            if (m_busy && $urandom_range(0, 15) == 0)
                bus.i_req_valid[IW'(m_own)] = 1'b0;
            slv_rdy = 1'($urandom_range(0, 1));
            noise   = 1'($urandom_range(0, 1));
            r64 = {$urandom, $urandom};
            bus.i_m_resp = r64[RW-1:0];
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
